up_ram_arbiter: RTL and testbench

//  Shares one dual-port block RAM (dc_block_ram: one write port, one read port,
//  1-cycle registered read) between two up-style requesters, A and B, e.g. two
//  up_axi bridges. Write port and read port are arbitrated independently, each

---
 rtl/up_ram_arbiter_pkg.sv | 13 +
 rtl/rr_arb2.sv | 33 +++
 rtl/up_ram_arbiter.sv | 161 ++++++++++++++++
 tb/tb_up_ram_arbiter.sv | 339 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/up_ram_arbiter_pkg.sv
// Shared constants for the up_ram_arbiter slice: request-slot indices and port numbering.
package up_ram_arbiter_pkg;

    localparam int unsigned NUM_SLOTS = 4;
    localparam int unsigned SLOT_AW   = 0;
    localparam int unsigned SLOT_AR   = 1;
    localparam int unsigned SLOT_BW   = 2;
    localparam int unsigned SLOT_BR   = 3;

    localparam int unsigned PORT_A = 0;
    localparam int unsigned PORT_B = 1;

endpackage

// File: rtl/rr_arb2.sv
// Two-requester round-robin arbiter; combinational one-hot grant, pointer moves past the winner.
module rr_arb2 (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    output logic [1:0] gnt
);

    // ptr_q = 0 favours req[0], ptr_q = 1 favours req[1]
    logic ptr_q, ptr_d;

    always_comb begin
        gnt   = req;
        ptr_d = ptr_q;
        if (&req) begin
            gnt = ptr_q ? 2'b10 : 2'b01;
        end
        if (gnt[0]) begin
            ptr_d = 1'b1;
        end else if (gnt[1]) begin
            ptr_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q <= 1'b0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/up_ram_arbiter.sv
// Shares one dual-port block RAM between two up-style requesters; independent
// round-robin arbitration of the write port and the read port.
module up_ram_arbiter
    import up_ram_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned BYTE_WIDTH = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    a_wreq,
    input  logic [ADDR_WIDTH-1:0]   a_waddr,
    input  logic [BYTE_WIDTH*8-1:0] a_wdata,
    input  logic [BYTE_WIDTH-1:0]   a_wben,
    output logic                    a_wack,
    input  logic                    a_rreq,
    input  logic [ADDR_WIDTH-1:0]   a_raddr,
    output logic [BYTE_WIDTH*8-1:0] a_rdata,
    output logic                    a_rack,
    input  logic                    b_wreq,
    input  logic [ADDR_WIDTH-1:0]   b_waddr,
    input  logic [BYTE_WIDTH*8-1:0] b_wdata,
    input  logic [BYTE_WIDTH-1:0]   b_wben,
    output logic                    b_wack,
    input  logic                    b_rreq,
    input  logic [ADDR_WIDTH-1:0]   b_raddr,
    output logic [BYTE_WIDTH*8-1:0] b_rdata,
    output logic                    b_rack,
    output logic                    ram_wr_en,
    output logic [BYTE_WIDTH-1:0]   ram_wr_ben,
    output logic [ADDR_WIDTH-1:0]   ram_wr_addr,
    output logic [BYTE_WIDTH*8-1:0] ram_wr_data,
    output logic                    ram_rd_en,
    output logic [ADDR_WIDTH-1:0]   ram_rd_addr,
    input  logic [BYTE_WIDTH*8-1:0] ram_rd_data,
    output logic [1:0]              err_ovf,
    input  logic                    err_clr
);

    localparam int unsigned DW = BYTE_WIDTH * 8;

    logic [NUM_SLOTS-1:0]  slot_valid_q;
    logic [ADDR_WIDTH-1:0] slot_addr_q [NUM_SLOTS];
    logic [DW-1:0]         slot_wdata_q [2];
    logic [BYTE_WIDTH-1:0] slot_wben_q [2];

    logic [NUM_SLOTS-1:0]  slot_req, slot_clr, slot_ovf;
    logic [ADDR_WIDTH-1:0] slot_addr_in [NUM_SLOTS];

    logic [1:0] wr_req, wr_gnt, wr_gnt_q;
    logic [1:0] rd_req, rd_gnt, rd_gnt_q;
    logic [1:0] err_q, err_d;

    always_comb begin
        slot_req = {b_rreq, b_wreq, a_rreq, a_wreq};
        slot_addr_in[SLOT_AW] = a_waddr;
        slot_addr_in[SLOT_AR] = a_raddr;
        slot_addr_in[SLOT_BW] = b_waddr;
        slot_addr_in[SLOT_BR] = b_raddr;
        slot_ovf = slot_req & slot_valid_q;
    end

    // Nothing is granted while in reset, so a reset cycle never strobes the RAM.
    assign wr_req = {slot_valid_q[SLOT_BW], slot_valid_q[SLOT_AW]} & ~{2{rst}};
    assign rd_req = {slot_valid_q[SLOT_BR], slot_valid_q[SLOT_AR]} & ~{2{rst}};

    rr_arb2 u_wr_arb (
        .clk (clk),
        .rst (rst),
        .req (wr_req),
        .gnt (wr_gnt)
    );

    rr_arb2 u_rd_arb (
        .clk (clk),
        .rst (rst),
        .req (rd_req),
        .gnt (rd_gnt)
    );

    always_comb begin
        slot_clr = '0;
        slot_clr[SLOT_AW] = wr_gnt[PORT_A];
        slot_clr[SLOT_BW] = wr_gnt[PORT_B];
        slot_clr[SLOT_AR] = rd_gnt[PORT_A];
        slot_clr[SLOT_BR] = rd_gnt[PORT_B];
        err_d = (err_clr ? 2'b00 : err_q)
              | {slot_ovf[SLOT_BW] | slot_ovf[SLOT_BR], slot_ovf[SLOT_AW] | slot_ovf[SLOT_AR]};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            slot_valid_q <= '0;
            for (int i = 0; i < NUM_SLOTS; i++) begin
                slot_addr_q[i] <= '0;
            end
            for (int p = 0; p < 2; p++) begin
                slot_wdata_q[p] <= '0;
                slot_wben_q[p]  <= '0;
            end
            wr_gnt_q <= '0;
            rd_gnt_q <= '0;
            err_q    <= '0;
        end else begin
            for (int i = 0; i < NUM_SLOTS; i++) begin
                if (slot_req[i] && !slot_valid_q[i]) begin
                    slot_valid_q[i] <= 1'b1;
                    slot_addr_q[i]  <= slot_addr_in[i];
                end else if (slot_clr[i]) begin
                    slot_valid_q[i] <= 1'b0;
                end
            end
            if (a_wreq && !slot_valid_q[SLOT_AW]) begin
                slot_wdata_q[PORT_A] <= a_wdata;
                slot_wben_q[PORT_A]  <= a_wben;
            end
            if (b_wreq && !slot_valid_q[SLOT_BW]) begin
                slot_wdata_q[PORT_B] <= b_wdata;
                slot_wben_q[PORT_B]  <= b_wben;
            end
            wr_gnt_q <= wr_gnt;
            rd_gnt_q <= rd_gnt;
            err_q    <= err_d;
        end
    end

    always_comb begin
        ram_wr_en   = |wr_gnt;
        ram_wr_addr = '0;
        ram_wr_data = '0;
        ram_wr_ben  = '0;
        if (wr_gnt[PORT_A]) begin
            ram_wr_addr = slot_addr_q[SLOT_AW];
            ram_wr_data = slot_wdata_q[PORT_A];
            ram_wr_ben  = slot_wben_q[PORT_A];
        end else if (wr_gnt[PORT_B]) begin
            ram_wr_addr = slot_addr_q[SLOT_BW];
            ram_wr_data = slot_wdata_q[PORT_B];
            ram_wr_ben  = slot_wben_q[PORT_B];
        end
        ram_rd_en   = |rd_gnt;
        ram_rd_addr = '0;
        if (rd_gnt[PORT_A]) begin
            ram_rd_addr = slot_addr_q[SLOT_AR];
        end else if (rd_gnt[PORT_B]) begin
            ram_rd_addr = slot_addr_q[SLOT_BR];
        end
    end

    // Acks come from last cycle's grants; masking with rst drops acks of pre-reset grants.
    always_comb begin
        a_wack  = wr_gnt_q[PORT_A] & ~rst;
        b_wack  = wr_gnt_q[PORT_B] & ~rst;
        a_rack  = rd_gnt_q[PORT_A] & ~rst;
        b_rack  = rd_gnt_q[PORT_B] & ~rst;
        a_rdata = a_rack ? ram_rd_data : '0;
        b_rdata = b_rack ? ram_rd_data : '0;
        err_ovf = err_q;
    end

endmodule

// File: tb/tb_up_ram_arbiter.sv
// Self-checking bench for up_ram_arbiter with a read-first block RAM model and ack scoreboard.
module tb_up_ram_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        a_wreq, a_rreq, b_wreq, b_rreq, err_clr;
    logic [31:0] a_waddr, a_raddr, b_waddr, b_raddr;
    logic [31:0] a_wdata, b_wdata;
    logic [3:0]  a_wben, b_wben;
    logic        a_wack, a_rack, b_wack, b_rack;
    logic [31:0] a_rdata, b_rdata;
    logic        ram_wr_en, ram_rd_en;
    logic [3:0]  ram_wr_ben;
    logic [31:0] ram_wr_addr, ram_wr_data, ram_rd_addr;
    logic [31:0] ram_rd_data;
    logic [1:0]  err_ovf;

    int n_checks = 0;
    int n_errors = 0;

    up_ram_arbiter #(
        .ADDR_WIDTH (32),
        .BYTE_WIDTH (4)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .a_wreq      (a_wreq),
        .a_waddr     (a_waddr),
        .a_wdata     (a_wdata),
        .a_wben      (a_wben),
        .a_wack      (a_wack),
        .a_rreq      (a_rreq),
        .a_raddr     (a_raddr),
        .a_rdata     (a_rdata),
        .a_rack      (a_rack),
        .b_wreq      (b_wreq),
        .b_waddr     (b_waddr),
        .b_wdata     (b_wdata),
        .b_wben      (b_wben),
        .b_wack      (b_wack),
        .b_rreq      (b_rreq),
        .b_raddr     (b_raddr),
        .b_rdata     (b_rdata),
        .b_rack      (b_rack),
        .ram_wr_en   (ram_wr_en),
        .ram_wr_ben  (ram_wr_ben),
        .ram_wr_addr (ram_wr_addr),
        .ram_wr_data (ram_wr_data),
        .ram_rd_en   (ram_rd_en),
        .ram_rd_addr (ram_rd_addr),
        .ram_rd_data (ram_rd_data),
        .err_ovf     (err_ovf),
        .err_clr     (err_clr)
    );

    always #5 clk = ~clk;

    // Read-first 256-word block RAM, 1-cycle registered read
    logic [31:0] mem [256];
    always @(posedge clk) begin
        if (ram_rd_en) ram_rd_data <= mem[ram_rd_addr[7:0]];
        if (ram_wr_en) begin
            for (int b = 0; b < 4; b++) begin
                if (ram_wr_ben[b]) mem[ram_wr_addr[7:0]][8*b +: 8] <= ram_wr_data[8*b +: 8];
            end
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Scoreboard: expected read data per port, expected write-ack counts per port
    logic [31:0] exp_ard[$];
    logic [31:0] exp_brd[$];
    int pend_aw = 0;
    int pend_bw = 0;

    always @(negedge clk) begin
        if (rst) begin
            chk("no_activity_in_reset", {a_wack, b_wack, a_rack, b_rack, ram_wr_en, ram_rd_en}, 0);
        end else begin
            if (a_wack) begin
                chk("a_wack_expected", (pend_aw > 0), 1);
                if (pend_aw > 0) pend_aw--;
            end
            if (b_wack) begin
                chk("b_wack_expected", (pend_bw > 0), 1);
                if (pend_bw > 0) pend_bw--;
            end
            if (a_rack) begin
                chk("a_rack_expected", (exp_ard.size() > 0), 1);
                if (exp_ard.size() > 0) chk("a_rdata", a_rdata, exp_ard.pop_front());
            end
            if (b_rack) begin
                chk("b_rack_expected", (exp_brd.size() > 0), 1);
                if (exp_brd.size() > 0) chk("b_rdata", b_rdata, exp_brd.pop_front());
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_reqs();
        a_wreq = 0; a_rreq = 0; b_wreq = 0; b_rreq = 0;
    endtask

    // Drives one request pulse; push=1 records its expected completion
    task automatic drive_req(input bit is_b, input bit is_rd, input logic [31:0] addr,
                             input logic [31:0] data, input logic [3:0] ben,
                             input bit push, input logic [31:0] exp);
        if (!is_b && !is_rd) begin a_wreq = 1; a_waddr = addr; a_wdata = data; a_wben = ben; end
        if (!is_b &&  is_rd) begin a_rreq = 1; a_raddr = addr; end
        if ( is_b && !is_rd) begin b_wreq = 1; b_waddr = addr; b_wdata = data; b_wben = ben; end
        if ( is_b &&  is_rd) begin b_rreq = 1; b_raddr = addr; end
        if (push) begin
            if (!is_b && !is_rd) pend_aw++;
            if ( is_b && !is_rd) pend_bw++;
            if (!is_b &&  is_rd) exp_ard.push_back(exp);
            if ( is_b &&  is_rd) exp_brd.push_back(exp);
        end
    endtask

    function automatic logic sel_ack(input bit is_b, input bit is_rd);
        if (is_rd) return is_b ? b_rack : a_rack;
        return is_b ? b_wack : a_wack;
    endfunction

    task automatic do_reset(input int cycles);
        clear_reqs();
        rst = 1;
        repeat (cycles) tick();
        rst = 0;
    endtask

    typedef struct {
        bit          is_b;
        bit          is_rd;
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  ben;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[12];
    int   rack_cnt;

    initial begin
        vecs[0]  = '{0, 0, 32'h10,  32'hDEADBEEF, 4'hF, 32'h0};
        vecs[1]  = '{0, 1, 32'h10,  32'h0,        4'h0, 32'hDEADBEEF};
        vecs[2]  = '{1, 0, 32'h11,  32'h12345678, 4'hF, 32'h0};
        vecs[3]  = '{1, 0, 32'h11,  32'hAAAAAAAA, 4'h3, 32'h0};
        vecs[4]  = '{1, 1, 32'h11,  32'h0,        4'h0, 32'h1234AAAA};
        vecs[5]  = '{0, 1, 32'h11,  32'h0,        4'h0, 32'h1234AAAA};
        vecs[6]  = '{0, 0, 32'h12,  32'h0,        4'hF, 32'h0};
        vecs[7]  = '{0, 0, 32'h12,  32'hCAFEF00D, 4'h8, 32'h0};
        vecs[8]  = '{1, 1, 32'h12,  32'h0,        4'h0, 32'hCA000000};
        vecs[9]  = '{1, 0, 32'h112, 32'h00000011, 4'h1, 32'h0};
        vecs[10] = '{0, 1, 32'h12,  32'h0,        4'h0, 32'hCA000011};
        vecs[11] = '{1, 1, 32'h112, 32'h0,        4'h0, 32'hCA000011};

        a_waddr = 0; a_wdata = 0; a_wben = 0; a_raddr = 0;
        b_waddr = 0; b_wdata = 0; b_wben = 0; b_raddr = 0;
        err_clr = 0;

        // Reset held with every request asserted
        rst = 1;
        a_wreq = 1; a_rreq = 1; b_wreq = 1; b_rreq = 1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("reset_acks", {a_wack, b_wack, a_rack, b_rack}, 0);
            chk("reset_ram_en", {ram_wr_en, ram_rd_en}, 0);
            chk("reset_err_ovf", err_ovf, 0);
        end
        clear_reqs();
        rst = 0;
        tick();

        // Table: one request at a time, grant at C+1, ack at C+2
        for (int i = 0; i < 12; i++) begin
            drive_req(vecs[i].is_b, vecs[i].is_rd, vecs[i].addr, vecs[i].data, vecs[i].ben,
                      1, vecs[i].exp);
            tick();
            clear_reqs();
            if (vecs[i].is_rd) begin
                chk("vec_rd_en", ram_rd_en, 1);
                chk("vec_rd_addr", ram_rd_addr, vecs[i].addr);
            end else begin
                chk("vec_wr_en", ram_wr_en, 1);
                chk("vec_wr_addr", ram_wr_addr, vecs[i].addr);
                chk("vec_wr_data", ram_wr_data, vecs[i].data);
                chk("vec_wr_ben", ram_wr_ben, vecs[i].ben);
            end
            chk("vec_no_early_ack", sel_ack(vecs[i].is_b, vecs[i].is_rd), 0);
            tick();
            chk("vec_ack", sel_ack(vecs[i].is_b, vecs[i].is_rd), 1);
            tick();
        end

        // Write contention right after reset: A first, then B
        do_reset(2);
        drive_req(0, 0, 32'h1, 32'h111, 4'hF, 1, 0);
        drive_req(1, 0, 32'h2, 32'h222, 4'hF, 1, 0);
        tick();
        clear_reqs();
        chk("contend1_first_addr", ram_wr_addr, 32'h1);
        tick();
        chk("contend1_second_addr", ram_wr_addr, 32'h2);
        chk("contend1_acks_a", {a_wack, b_wack}, 2'b10);
        tick();
        chk("contend1_acks_b", {a_wack, b_wack}, 2'b01);
        tick();
        // A lone A write moves the pointer to B
        drive_req(0, 0, 32'h3, 32'h333, 4'hF, 1, 0);
        tick(); clear_reqs(); tick(); tick();
        drive_req(0, 0, 32'h4, 32'h444, 4'hF, 1, 0);
        drive_req(1, 0, 32'h5, 32'h555, 4'hF, 1, 0);
        tick();
        clear_reqs();
        chk("contend2_first_addr", ram_wr_addr, 32'h5);
        tick();
        chk("contend2_second_addr", ram_wr_addr, 32'h4);
        chk("contend2_acks_b", {a_wack, b_wack}, 2'b01);
        tick();
        chk("contend2_acks_a", {a_wack, b_wack}, 2'b10);
        tick();

        // Same-cycle write and read of one address: read returns old data
        drive_req(0, 0, 32'h20, 32'h1, 4'hF, 1, 0);
        tick(); clear_reqs(); tick(); tick();
        drive_req(0, 0, 32'h20, 32'h2, 4'hF, 1, 0);
        drive_req(1, 1, 32'h20, 0, 0, 1, 32'h1);
        tick();
        clear_reqs();
        chk("rw_same_cycle_en", {ram_wr_en, ram_rd_en}, 2'b11);
        tick();
        chk("rw_old_data", {b_rack, b_rdata}, {1'b1, 32'h1});
        tick();
        drive_req(0, 1, 32'h20, 0, 0, 1, 32'h2);
        tick(); clear_reqs(); tick();
        chk("rw_new_data", {a_rack, a_rdata}, {1'b1, 32'h2});
        tick();

        // Overflow on port A: second read dropped, first served once
        drive_req(0, 1, 32'h10, 0, 0, 1, 32'hDEADBEEF);
        tick();
        drive_req(0, 1, 32'h11, 0, 0, 0, 0);
        chk("ovf_not_yet", err_ovf, 2'b00);
        tick();
        clear_reqs();
        chk("ovf_a_set", err_ovf, 2'b01);
        rack_cnt = 0;
        for (int i = 0; i < 4; i++) begin
            if (a_rack) begin
                rack_cnt++;
                chk("ovf_first_addr_data", a_rdata, 32'hDEADBEEF);
            end
            tick();
        end
        chk("ovf_single_ack", rack_cnt, 1);
        err_clr = 1;
        tick();
        err_clr = 0;
        chk("ovf_cleared", err_ovf, 2'b00);

        // err_clr coinciding with a new overflow: set wins
        drive_req(0, 1, 32'h10, 0, 0, 1, 32'hDEADBEEF);
        tick();
        drive_req(0, 1, 32'h10, 0, 0, 0, 0);
        err_clr = 1;
        tick();
        clear_reqs();
        err_clr = 0;
        chk("ovf_set_wins", err_ovf, 2'b01);
        tick();
        err_clr = 1;
        tick();
        err_clr = 0;

        // Overflow on port B write slot
        drive_req(1, 0, 32'h30, 32'h5, 4'hF, 1, 0);
        tick();
        drive_req(1, 0, 32'h31, 32'h6, 4'hF, 0, 0);
        tick();
        clear_reqs();
        chk("ovf_b_set", err_ovf, 2'b10);
        tick();
        err_clr = 1;
        tick();
        err_clr = 0;
        chk("ovf_b_cleared", err_ovf, 2'b00);

        // Reset in the cycle after a grant: no ack, pending B slot discarded
        drive_req(0, 0, 32'h40, 32'h7, 4'hF, 0, 0);
        tick();
        clear_reqs();
        chk("midrst_grant", ram_wr_en, 1);
        drive_req(1, 0, 32'h41, 32'h8, 4'hF, 0, 0);
        tick();
        clear_reqs();
        rst = 1;
        #1;
        chk("midrst_no_ack", {a_wack, b_wack}, 2'b00);
        chk("midrst_no_grant", ram_wr_en, 0);
        tick();
        tick();
        rst = 0;
        for (int i = 0; i < 3; i++) begin
            chk("post_rst_idle", {a_wack, b_wack, ram_wr_en}, 0);
            tick();
        end
        drive_req(0, 0, 32'h42, 32'h99, 4'hF, 1, 0);
        tick(); clear_reqs(); tick();
        chk("post_rst_wack", a_wack, 1);
        tick();
        drive_req(1, 1, 32'h42, 0, 0, 1, 32'h99);
        tick(); clear_reqs(); tick();
        chk("post_rst_rack", {b_rack, b_rdata}, {1'b1, 32'h99});
        tick(); tick();

        chk("sb_drained", {exp_ard.size(), exp_brd.size(), pend_aw, pend_bw}, 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
